sort_arbiter: RTL and testbench
===============================

SORT_ARBITER -- requirements
Module: sort_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of packet requesters (2..8).
REQ-002 SHALL have parameter DWIDTH, default 32, data word width.
REQ-003 SHALL have parameter AWIDTH, default 12, sorter address width; maximum packet is 2**AWIDTH words.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port arst_n_i, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have ports data_i/sop_i/eop_i/val_i, input, [NREQ][DWIDTH]/[NREQ]/[NREQ]/[NREQ], requester packet streams.
REQ-007 SHALL have port ready_o, output, [NREQ]; a word transfers when val_i[k] and ready_o[k] are both high.
REQ-008 SHALL have ports srt_data_o/srt_sop_o/srt_eop_o/srt_val_o, output, DWIDTH/1/1/1, stream into the sorter.
REQ-009 SHALL have ports srt_data_i/srt_sop_i/srt_eop_i/srt_val_i/srt_busy_i, input, DWIDTH/1/1/1/1, sorter result stream and busy.
REQ-010 SHALL have ports data_o/sop_o/eop_o/val_o, output, DWIDTH/1/1/1, sorted result stream.
REQ-011 SHALL have port tag_o, output, $clog2(NREQ), index of the requester owning the current result; valid while val_o is high.
REQ-012 SHALL have port trunc_o, output, 1, one-cycle pulse when an oversize packet is truncated.

Function
REQ-013 SHALL implement FSM IDLE -> FWD -> (DROP) -> WAIT -> IDLE.
REQ-014 IDLE: request k = val_i[k] & sop_i[k]; when any request and srt_busy_i low, SHALL register a round-robin grant and enter FWD next cycle.
REQ-015 Round-robin search SHALL start at (last grant + 1) mod NREQ; a lone requester is granted back-to-back.
REQ-016 FWD: ready_o SHALL be high for the granted index only; all other ready_o low in every state.
REQ-017 Each accepted word SHALL appear on srt_* exactly one cycle later; srt_val_o low in cycles with no transfer (input gaps allowed).
REQ-018 srt_sop_o SHALL be high only on the first forwarded word; sop_i on later words SHALL be ignored.
REQ-019 Accepted eop_i SHALL be forwarded as srt_eop_o and move FSM to WAIT; a single-word packet (sop_i & eop_i) forwards with both flags.
REQ-020 On the 2**AWIDTH-th word without eop_i, SHALL force srt_eop_o, pulse trunc_o, and enter DROP.
REQ-021 DROP: ready_o of granted requester SHALL stay high, words discarded (srt_val_o low) until eop_i accepted, then WAIT.
REQ-022 WAIT: SHALL return to IDLE in the cycle after srt_val_i & srt_eop_i is seen and srt_busy_i is low; no grant occurs in WAIT.
REQ-023 Result path: data_o/sop_o/eop_o/val_o SHALL equal srt_* inputs delayed one cycle; tag_o SHALL hold the grant index latched at grant time.
REQ-024 At most one packet SHALL be in flight in the sorter at any time.
REQ-025 Word counter SHALL be AWIDTH+1 bits, cleared on grant.

Reset
REQ-026 On arst_n_i low, all outputs SHALL go to 0, FSM to IDLE, word counter to 0, last-grant pointer to NREQ-1 (requester 0 wins first).
REQ-027 Reset mid-packet SHALL abandon the packet; the sorter shares arst_n_i.

Configuration
REQ-028 With SORT_ARB_STAT_EN defined, SHALL add output pkt_cnt_o [NREQ][16]: per-requester count of completed results (val_o & eop_o), saturating at 16'hFFFF, reset to 0.
REQ-029 Without SORT_ARB_STAT_EN, pkt_cnt_o and its counters SHALL not exist.

Structure
REQ-030 Package sort_arb_pkg SHALL hold the FSM state enum and the tag-width function.
REQ-031 Round-robin selection SHALL be a sub-module rr_arbiter (request vector, pointer in; one-hot grant, index out).

Verification
REQ-032 Single requester 0, packet {5,1,3} -> srt_* forwards 3 words, later data_o {1,3,5} with tag_o=0, sop/eop on first/last.
REQ-033 Requesters 0 and 1 both present sop after reset -> 0 served first, then 1; repeat -> order 0,1 again.
REQ-034 Requester 1 sends 2**AWIDTH+3 words -> srt_eop_o on word 4096, trunc_o pulses once, 3 words dropped, ready_o[1] high until eop_i.
REQ-035 Request asserted while srt_busy_i high -> no ready_o until busy low and result eop seen.
REQ-036 Single-word packet {7} -> srt_sop_o & srt_eop_o same cycle, data_o 7, tag_o correct.
REQ-037 arst_n_i pulsed mid-FWD -> all outputs 0 next edge, next grant goes to requester 0.

Source files
------------

// File: rtl/sort_arb_pkg.sv
// sort_arb_pkg: FSM state type and tag-width helper shared by sort_arbiter and rr_arbiter.
package sort_arb_pkg;
  typedef enum logic [1:0] {IDLE, FWD, DROP, WAIT} state_e;
  function automatic int tag_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sort_arbiter_rr.sv
// rr_arbiter: round-robin pick; the search starts one past the last granted index.
module rr_arbiter import sort_arb_pkg::*; #(
  parameter int N = 2,
  localparam int TW = tag_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [TW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [TW-1:0] idx_o
);
  logic [TW-1:0] j;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    j = '0;
    for (int i = N; i >= 1; i--) begin
      j = TW'((int'(ptr_i) + i) % N);
      if (req_i[j]) begin
        gnt_o = '0;
        gnt_o[j] = 1'b1;
        idx_o = j;
      end
    end
  end
endmodule

// File: rtl/sort_arbiter.sv
// sort_arbiter: grants one requester at a time into a shared sorter and returns the sorted result.
// Define SORT_ARB_STAT_EN to add per-requester completed-result counters on pkt_cnt_o.
module sort_arbiter import sort_arb_pkg::*; #(
  parameter int NREQ = 2,
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 12,
  localparam int TW = tag_w(NREQ)
) (
  input  logic                         clk_i,
  input  logic                         arst_n_i,
  input  logic [NREQ-1:0][DWIDTH-1:0]  data_i,
  input  logic [NREQ-1:0]              sop_i,
  input  logic [NREQ-1:0]              eop_i,
  input  logic [NREQ-1:0]              val_i,
  output logic [NREQ-1:0]              ready_o,
  output logic [DWIDTH-1:0]            srt_data_o,
  output logic                         srt_sop_o,
  output logic                         srt_eop_o,
  output logic                         srt_val_o,
  input  logic [DWIDTH-1:0]            srt_data_i,
  input  logic                         srt_sop_i,
  input  logic                         srt_eop_i,
  input  logic                         srt_val_i,
  input  logic                         srt_busy_i,
  output logic [DWIDTH-1:0]            data_o,
  output logic                         sop_o,
  output logic                         eop_o,
  output logic                         val_o,
  output logic [TW-1:0]                tag_o,
  output logic                         trunc_o
`ifdef SORT_ARB_STAT_EN
  ,
  output logic [NREQ-1:0][15:0]        pkt_cnt_o
`endif
);
  localparam logic [AWIDTH:0] LAST = {1'b0, {AWIDTH{1'b1}}};
  state_e              state_q;
  logic [TW-1:0]       grant_q, last_q, gnt_idx;
  logic [NREQ-1:0]     ready_q, gnt;
  logic [AWIDTH:0]     cnt_q;
  logic                done_q, trunc_q, srt_sop_q, srt_eop_q, srt_val_q;
  logic [DWIDTH-1:0]   srt_data_q, data_q;
  logic                sop_q, eop_q, val_q;
  logic                xfer, eop_w, last_word, res_eop;
  rr_arbiter #(.N(NREQ)) u_rr (
    .req_i (val_i & sop_i),
    .ptr_i (last_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );
  assign xfer      = |(val_i & ready_q);
  assign eop_w     = eop_i[grant_q];
  assign last_word = cnt_q == LAST;
  assign res_eop   = srt_val_i & srt_eop_i;
  // done_q remembers a result eop that arrives while the sorter still reports busy
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= TW'(NREQ - 1);
      cnt_q      <= '0;
      done_q     <= 1'b0;
      ready_q    <= '0;
      srt_data_q <= '0;
      srt_sop_q  <= 1'b0;
      srt_eop_q  <= 1'b0;
      srt_val_q  <= 1'b0;
      trunc_q    <= 1'b0;
    end else begin
      srt_sop_q <= 1'b0;
      srt_eop_q <= 1'b0;
      srt_val_q <= 1'b0;
      trunc_q   <= 1'b0;
      case (state_q)
        IDLE: if ((|gnt) && !srt_busy_i) begin
          state_q <= FWD;
          grant_q <= gnt_idx;
          last_q  <= gnt_idx;
          ready_q <= gnt;
          cnt_q   <= '0;
          done_q  <= 1'b0;
        end
        FWD: if (xfer) begin
          srt_val_q  <= 1'b1;
          srt_data_q <= data_i[grant_q];
          srt_sop_q  <= cnt_q == '0;
          srt_eop_q  <= eop_w | last_word;
          trunc_q    <= last_word & ~eop_w;
          cnt_q      <= cnt_q + (AWIDTH + 1)'(1);
          if (eop_w) begin
            state_q <= WAIT;
            ready_q <= '0;
          end else if (last_word) state_q <= DROP;
        end
        DROP: begin
          done_q <= done_q | res_eop;
          if (xfer && eop_w) begin
            state_q <= WAIT;
            ready_q <= '0;
          end
        end
        WAIT: begin
          done_q <= done_q | res_eop;
          if ((done_q | res_eop) && !srt_busy_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) {data_q, sop_q, eop_q, val_q} <= '0;
    else {data_q, sop_q, eop_q, val_q} <= {srt_data_i, srt_sop_i, srt_eop_i, srt_val_i};
  end
  assign ready_o    = ready_q;
  assign srt_data_o = srt_data_q;
  assign srt_sop_o  = srt_sop_q;
  assign srt_eop_o  = srt_eop_q;
  assign srt_val_o  = srt_val_q;
  assign data_o     = data_q;
  assign sop_o      = sop_q;
  assign eop_o      = eop_q;
  assign val_o      = val_q;
  assign tag_o      = grant_q;
  assign trunc_o    = trunc_q;
`ifdef SORT_ARB_STAT_EN
  logic [NREQ-1:0][15:0] pkt_cnt_q;
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) pkt_cnt_q <= '0;
    else if (val_q && eop_q && pkt_cnt_q[grant_q] != 16'hFFFF)
      pkt_cnt_q[grant_q] <= pkt_cnt_q[grant_q] + 16'd1;
  end
  assign pkt_cnt_o = pkt_cnt_q;
`endif
endmodule

// File: tb/tb_sort_arbiter.sv
// tb_sort_arbiter: random and directed packets through sort_arbiter with a behavioural sorter and scoreboard.
module tb_sort_arbiter;
  import sort_arb_pkg::*;
  localparam int NREQ = 3;
  localparam int DW = 16;
  localparam int AW = 12;
  localparam int TW = tag_w(NREQ);
  localparam int MAXW = 1 << AW;
  typedef logic [DW-1:0] word_t;

  logic clk = 1'b0;
  logic arst_n_i = 1'b0;
  logic [NREQ-1:0][DW-1:0] data_i;
  logic [NREQ-1:0] sop_i, eop_i, val_i, ready_o;
  logic [DW-1:0] srt_data_o, srt_data_i, data_o;
  logic srt_sop_o, srt_eop_o, srt_val_o;
  logic srt_sop_i, srt_eop_i, srt_val_i, srt_busy_i;
  logic sop_o, eop_o, val_o, trunc_o;
  logic [TW-1:0] tag_o;
`ifdef SORT_ARB_STAT_EN
  logic [NREQ-1:0][15:0] pkt_cnt_o;
`endif

  sort_arbiter #(.NREQ(NREQ), .DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk_i(clk), .arst_n_i(arst_n_i),
    .data_i(data_i), .sop_i(sop_i), .eop_i(eop_i), .val_i(val_i), .ready_o(ready_o),
    .srt_data_o(srt_data_o), .srt_sop_o(srt_sop_o), .srt_eop_o(srt_eop_o), .srt_val_o(srt_val_o),
    .srt_data_i(srt_data_i), .srt_sop_i(srt_sop_i), .srt_eop_i(srt_eop_i), .srt_val_i(srt_val_i),
    .srt_busy_i(srt_busy_i),
    .data_o(data_o), .sop_o(sop_o), .eop_o(eop_o), .val_o(val_o), .tag_o(tag_o), .trunc_o(trunc_o)
`ifdef SORT_ARB_STAT_EN
    , .pkt_cnt_o(pkt_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // requester driver state: current packet words and next word index
  word_t pq[NREQ][$];
  int pos[NREQ];
  logic [NREQ-1:0] xf = '0;
  bit gaps = 1'b1, force_busy = 1'b0;

  // scoreboard / model state
  word_t exp_d[$], tmp[$];
  int exp_t[$];
  bit exp_s[$], exp_e[$];
  int order_log[$];
  int res_cnt[NREQ];
  int cur = 0, last_m = NREQ - 1, fw = 0, ntrunc = 0;
  bit active = 1'b0, dropping = 1'b0;
  logic pv = 1'b0, ps = 1'b0, pe = 1'b0, pt = 1'b0;
  word_t pd = '0;
  logic [NREQ-1:0] req_prev = '0, rdy_prev = '0;
  logic busy_prev = 1'b0;

  function automatic bit pq_busy();
    for (int k = 0; k < NREQ; k++) if (pq[k].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic rand_pkt(input int k, input int len);
    for (int i = 0; i < len; i++) pq[k].push_back(word_t'($urandom_range(0, 255)));
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while ((pq_busy() || exp_d.size() > 0 || active || srt_busy_i) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(n < budget), 64'(1));
  endtask

  // requester drivers
  initial begin
    val_i = '0; sop_i = '0; eop_i = '0; data_i = '0;
    for (int k = 0; k < NREQ; k++) pos[k] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NREQ; k++) begin
        if (!arst_n_i) begin
          pq[k].delete();
          pos[k] = 0;
        end else if (xf[k]) begin
          pos[k]++;
          if (pos[k] == pq[k].size()) begin
            pq[k].delete();
            pos[k] = 0;
          end
        end
        if (pq[k].size() == 0) begin
          val_i[k] = 1'b0; sop_i[k] = 1'b0; eop_i[k] = 1'b0;
        end else begin
          val_i[k]  = !(gaps && pos[k] > 0 && $urandom_range(0, 3) == 0);
          data_i[k] = pq[k][pos[k]];
          sop_i[k]  = (pos[k] == 0) || ($urandom_range(0, 7) == 0);
          eop_i[k]  = pos[k] == pq[k].size() - 1;
        end
      end
    end
  end

  // behavioural sorter: collect a packet, sort ascending, emit after a random delay
  initial begin
    word_t col[$], res[$];
    int dly, hold;
    bit first;
    dly = 0; hold = 0; first = 1'b0;
    srt_data_i = '0; srt_sop_i = 1'b0; srt_eop_i = 1'b0; srt_val_i = 1'b0; srt_busy_i = 1'b0;
    forever begin
      @(posedge clk or negedge arst_n_i);
      if (!arst_n_i) begin
        col.delete(); res.delete(); hold = 0; dly = 0;
        srt_val_i = 1'b0; srt_sop_i = 1'b0; srt_eop_i = 1'b0; srt_busy_i = 1'b0;
        continue;
      end
      #1;
      srt_val_i = 1'b0; srt_sop_i = 1'b0; srt_eop_i = 1'b0;
      if (res.size() > 0) begin
        if (dly > 0) dly--;
        else begin
          srt_val_i  = 1'b1;
          srt_data_i = res.pop_front();
          srt_sop_i  = first;
          first      = 1'b0;
          srt_eop_i  = res.size() == 0;
          if (srt_eop_i) hold = $urandom_range(0, 2);
        end
      end else if (hold > 0) hold--;
      if (srt_val_o) begin
        col.push_back(srt_data_o);
        if (srt_eop_o) begin
          col.sort();
          res = col;
          col.delete();
          dly = $urandom_range(0, 3);
          first = 1'b1;
        end
      end
      srt_busy_i = force_busy || res.size() > 0 || hold > 0 || col.size() > 0;
    end
  end

  // monitor: forwarding, arbitration and result checks against the model
  always @(negedge clk) begin : mon
    logic [NREQ-1:0] rise, pred, exp_rdy;
    int q, n;
    if (!arst_n_i) begin
      pv = 1'b0; pt = 1'b0; active = 1'b0; dropping = 1'b0; last_m = NREQ - 1;
      exp_d.delete(); exp_t.delete(); exp_s.delete(); exp_e.delete();
      xf = '0; rdy_prev = '0; req_prev = '0; busy_prev = 1'b0;
      for (int k = 0; k < NREQ; k++) res_cnt[k] = 0;
    end else begin
      check("srt_val", 64'(srt_val_o), 64'(pv));
      if (pv) begin
        check("srt_data", 64'(srt_data_o), 64'(pd));
        check("srt_sop", 64'(srt_sop_o), 64'(ps));
        check("srt_eop", 64'(srt_eop_o), 64'(pe));
      end
      check("trunc", 64'(trunc_o), 64'(pt));
      if (trunc_o) ntrunc++;
      rise = ready_o & ~rdy_prev;
      if (rise != '0) begin
        pred = '0;
        for (int j = 1; j <= NREQ; j++) begin
          q = (last_m + j) % NREQ;
          if (pred == '0 && |((req_prev >> q) & NREQ'(1))) pred = NREQ'(1) << q;
        end
        check("grant", 64'(rise), 64'(pred));
        check("grant_ok", 64'({exp_d.size() == 0, busy_prev}), 64'(2'b10));
        for (int k = 0; k < NREQ; k++) if (|((rise >> k) & NREQ'(1))) cur = k;
        order_log.push_back(cur);
        last_m = cur; active = 1'b1; dropping = 1'b0; fw = 0;
        n = (pq[cur].size() < MAXW) ? pq[cur].size() : MAXW;
        tmp.delete();
        for (int i = 0; i < n; i++) tmp.push_back(pq[cur][i]);
        tmp.sort();
        for (int i = 0; i < n; i++) begin
          exp_d.push_back(tmp[i]); exp_t.push_back(cur);
          exp_s.push_back(i == 0); exp_e.push_back(i == n - 1);
        end
      end
      exp_rdy = active ? NREQ'(1) << cur : '0;
      check("ready", 64'(ready_o), 64'(exp_rdy));
      xf = val_i & ready_o;
      pv = 1'b0; pt = 1'b0;
      if (active && |((xf >> cur) & NREQ'(1))) begin
        if (!dropping) begin
          pv = 1'b1;
          pd = data_i[cur];
          ps = fw == 0;
          pe = eop_i[cur] || fw == MAXW - 1;
          pt = fw == MAXW - 1 && !eop_i[cur];
          dropping = pt;
          fw++;
        end
        if (eop_i[cur]) active = 1'b0;
      end
      if (val_o) begin
        if (exp_d.size() == 0) check("res_extra", 64'(val_o), 64'(0));
        else begin
          check("data_o", 64'(data_o), 64'(exp_d[0]));
          check("tag_o", 64'(tag_o), 64'(exp_t[0]));
          check("sop_o", 64'(sop_o), 64'(exp_s[0]));
          check("eop_o", 64'(eop_o), 64'(exp_e[0]));
          if (exp_e[0]) res_cnt[exp_t[0]]++;
          void'(exp_d.pop_front()); void'(exp_t.pop_front());
          void'(exp_s.pop_front()); void'(exp_e.pop_front());
        end
      end
      req_prev = val_i & sop_i;
      busy_prev = srt_busy_i;
      rdy_prev = ready_o;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(ready_o), 64'(0));
    check("rst_srt_val", 64'(srt_val_o), 64'(0));
    check("rst_srt_data", 64'(srt_data_o), 64'(0));
    check("rst_val_o", 64'(val_o), 64'(0));
    check("rst_data_o", 64'(data_o), 64'(0));
    check("rst_tag", 64'(tag_o), 64'(0));
    check("rst_trunc", 64'(trunc_o), 64'(0));
    arst_n_i = 1'b1;
    @(negedge clk);
    // packet {5,1,3} from requester 0
    pq[0].push_back(16'd5); pq[0].push_back(16'd1); pq[0].push_back(16'd3);
    wait_done("done_513", 200);
    // single-word packet {7} from requester 1
    pq[1].push_back(16'd7);
    wait_done("done_7", 200);
    // simultaneous requests from 0 and 1, twice
    order_log.delete();
    repeat (2) begin
      rand_pkt(0, 3);
      rand_pkt(1, 3);
      wait_done("done_pair", 400);
    end
    check("order_n", 64'(order_log.size()), 64'(4));
    for (int i = 0; i < order_log.size() && i < 4; i++) check("order", 64'(order_log[i]), 64'(i % 2));
    // sorter busy blocks any grant
    force_busy = 1'b1;
    @(negedge clk);
    rand_pkt(2, 4);
    repeat (8) begin
      @(negedge clk);
      check("busy_ready", 64'(ready_o), 64'(0));
    end
    force_busy = 1'b0;
    wait_done("done_busy", 400);
    // oversize packet truncated after MAXW words
    ntrunc = 0;
    rand_pkt(1, MAXW + 3);
    wait_done("done_trunc", 20000);
    check("trunc_cnt", 64'(ntrunc), 64'(1));
    // random traffic
    for (int t = 0; t < 40; t++) begin
      int k;
      k = $urandom_range(0, NREQ - 1);
      n = 0;
      while (pq[k].size() > 0 && n < 2000) begin
        @(negedge clk);
        n++;
      end
      check("slot_free", 64'(n < 2000), 64'(1));
      rand_pkt(k, $urandom_range(1, 8));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_done("done_rand", 5000);
`ifdef SORT_ARB_STAT_EN
    for (int k = 0; k < NREQ; k++) check("pkt_cnt", 64'(pkt_cnt_o[k]), 64'(res_cnt[k]));
`endif
    // reset in the middle of a forwarded packet
    rand_pkt(2, 20);
    n = 0;
    while (!(active && cur == 2 && fw >= 3) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("mid_fwd", 64'(n < 300), 64'(1));
    #2 arst_n_i = 1'b0;
    @(negedge clk);
    check("arst_ready", 64'(ready_o), 64'(0));
    check("arst_srt_val", 64'(srt_val_o), 64'(0));
    check("arst_val_o", 64'(val_o), 64'(0));
    check("arst_tag", 64'(tag_o), 64'(0));
    check("arst_trunc", 64'(trunc_o), 64'(0));
    @(negedge clk);
    arst_n_i = 1'b1;
    @(negedge clk);
    order_log.delete();
    rand_pkt(2, 2);
    rand_pkt(0, 2);
    wait_done("done_post_rst", 400);
    check("post_rst_n", 64'(order_log.size()), 64'(2));
    if (order_log.size() > 0) check("post_rst_first", 64'(order_log[0]), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end
endmodule
